// File: rtl/stage.sv
`default_nettype none
// ============================================================================
// Module      : stage
// Description : One trigger stage of a logic-analyser trigger sequencer.
//               Compares strobed samples against a masked value (parallel, or
//               serial on one channel when STAGE_SERIAL_EN is defined). It
//               waits for a global level, optionally counts a delay in strobes,
//               then fires a one-cycle match pulse and an optional sticky
//               run flag.
// Options     : STAGE_SERIAL_EN - implements the serial shift-register
//               compare mode (cfg[26]).
// Revision    : 1.0 - initial release
// ============================================================================
module stage (
    input  logic        clk_i,
    input  logic        rst_in,
    input  logic [31:0] smpls_i,
    input  logic        stb_i,
    input  logic [31:0] cmd_i,
    input  logic        wr_mask_i,
    input  logic        wr_val_i,
    input  logic        wr_cfg_i,
    input  logic        arm_i,
    input  logic [1:0]  lvl_i,
    output logic        match_o,
    output logic        run_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DELAY = 2'd2,
        DONE  = 2'd3
    } state_t;

    logic [31:0] r_mask;
    logic [31:0] r_value;
    logic [31:0] r_cfg;
    logic [15:0] r_cnt;
    state_t      r_state;

    logic [15:0] w_delay;
    logic [1:0]  w_level;
    logic        w_start;
    logic [31:0] w_cmp;
    logic        w_hit;
    logic        w_active;

    assign w_delay = r_cfg[15:0];
    assign w_level = r_cfg[17:16];
    assign w_start = r_cfg[27];

`ifdef STAGE_SERIAL_EN
    logic [31:0] r_sreg;
    logic [31:0] w_next_sreg;
    logic [4:0]  w_channel;
    logic        w_unused_cfg;

    assign w_channel    = r_cfg[24:20];
    assign w_next_sreg  = {r_sreg[30:0], smpls_i[w_channel]};
    assign w_cmp        = r_cfg[26] ? w_next_sreg : smpls_i;
    assign w_unused_cfg = ^{r_cfg[31:28], r_cfg[25], r_cfg[19:18]};

    // Serial history shifts on every strobe regardless of FSM state
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_sreg <= '0;
        end else if (stb_i) begin
            r_sreg <= w_next_sreg;
        end
    end
`else
    logic w_unused_cfg;

    assign w_cmp        = smpls_i;
    assign w_unused_cfg = ^{r_cfg[31:18]};
`endif

    assign w_hit    = ((w_cmp ^ r_value) & r_mask) == 32'd0;
    assign w_active = (r_state == ARMED) && (lvl_i >= w_level);

    // Configuration registers; independent writes may land in the same cycle
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_mask  <= '0;
            r_value <= '0;
            r_cfg   <= '0;
        end else begin
            if (wr_mask_i) r_mask  <= cmd_i;
            if (wr_val_i)  r_value <= cmd_i;
            if (wr_cfg_i)  r_cfg   <= cmd_i;
        end
    end

    // Trigger FSM with registered match pulse and sticky run flag
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            match_o <= 1'b0;
            run_o   <= 1'b0;
        end else begin
            match_o <= 1'b0;
            if (arm_i) begin
                // Re-arming overrides any firing that would happen this cycle
                r_state <= ARMED;
                r_cnt   <= '0;
                run_o   <= 1'b0;
            end else if (stb_i) begin
                case (r_state)
                    ARMED: begin
                        if (w_active && w_hit) begin
                            if (w_delay == 16'd0) begin
                                match_o <= 1'b1;
                                r_state <= DONE;
                                if (w_start) run_o <= 1'b1;
                            end else begin
                                r_cnt   <= w_delay;
                                r_state <= DELAY;
                            end
                        end
                    end
                    DELAY: begin
                        // Counter is at least 1 on entry; the strobe reaching 0 fires
                        r_cnt <= r_cnt - 16'd1;
                        if (r_cnt == 16'd1) begin
                            match_o <= 1'b1;
                            r_state <= DONE;
                            if (w_start) run_o <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage
// Description : Self-checking bench for stage. Each driven cycle pushes the
//               expected match/run outputs to a scoreboard that a monitor
//               pops and compares just after the following rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] smpls;
    logic        stb;
    logic [31:0] cmd;
    logic        wr_mask;
    logic        wr_val;
    logic        wr_cfg;
    logic        arm;
    logic [1:0]  lvl;
    logic        match;
    logic        run;

    int          n_total;
    int          n_pass;

    logic [1:0]  exp_q[$];
    string       tag_q[$];

    stage dut (
        .clk_i     (clk),
        .rst_in    (rst_n),
        .smpls_i   (smpls),
        .stb_i     (stb),
        .cmd_i     (cmd),
        .wr_mask_i (wr_mask),
        .wr_val_i  (wr_val),
        .wr_cfg_i  (wr_cfg),
        .arm_i     (arm),
        .lvl_i     (lvl),
        .match_o   (match),
        .run_o     (run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Scoreboard consumer: outputs settle just after the rising edge
    always @(posedge clk) begin
        logic [1:0] e;
        string      t;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check({t, "/match"}, {31'd0, match}, {31'd0, e[1]});
            check({t, "/run"},   {31'd0, run},   {31'd0, e[0]});
        end
    end

    // Queue expectation for the coming edge, advance to next falling edge
    task automatic tick(input logic em, input logic er, input string tag);
        exp_q.push_back({em, er});
        tag_q.push_back(tag);
        @(posedge clk);
        @(negedge clk);
        stb     = 1'b0;
        wr_mask = 1'b0;
        wr_val  = 1'b0;
        wr_cfg  = 1'b0;
        arm     = 1'b0;
    endtask

    task automatic wr(input int sel, input logic [31:0] d, input logic er, input string tag);
        cmd = d;
        if (sel == 0) wr_mask = 1'b1;
        if (sel == 1) wr_val  = 1'b1;
        if (sel == 2) wr_cfg  = 1'b1;
        tick(1'b0, er, tag);
    endtask

    task automatic strobe(input logic [31:0] d, input logic em, input logic er, input string tag);
        smpls = d;
        stb   = 1'b1;
        tick(em, er, tag);
    endtask

    task automatic do_arm(input string tag);
        arm = 1'b1;
        tick(1'b0, 1'b0, tag);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        smpls   = '0;
        stb     = 1'b0;
        cmd     = '0;
        wr_mask = 1'b0;
        wr_val  = 1'b0;
        wr_cfg  = 1'b0;
        arm     = 1'b0;
        lvl     = 2'd0;

        #1;
        check("reset/match", {31'd0, match}, 32'd0);
        check("reset/run",   {31'd0, run},   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Parallel compare, no delay, no start
        wr(0, 32'h0000_00FF, 1'b0, "p/wmask");
        wr(1, 32'h0000_00A5, 1'b0, "p/wval");
        wr(2, 32'h0000_0000, 1'b0, "p/wcfg");
        strobe(32'h1234_56A5, 1'b0, 1'b0, "p/idle");
        do_arm("p/arm");
        strobe(32'h1234_56A4, 1'b0, 1'b0, "p/miss");
        tick(1'b0, 1'b0, "p/gap");
        strobe(32'h1234_56A5, 1'b1, 1'b0, "p/hit");
        tick(1'b0, 1'b0, "p/after");
        strobe(32'h1234_56A5, 1'b0, 1'b0, "p/done");

        // Delay of 3 strobes with start; gaps and a mid-delay cfg write
        wr(2, 32'h0800_0003, 1'b0, "d/wcfg");
        do_arm("d/arm");
        strobe(32'h1234_56A5, 1'b0, 1'b0, "d/hit");
        tick(1'b0, 1'b0, "d/gap1");
        strobe(32'h0000_0000, 1'b0, 1'b0, "d/s1");
        wr(2, 32'h0800_0007, 1'b0, "d/wcfg2");
        strobe(32'h0000_0000, 1'b0, 1'b0, "d/s2");
        strobe(32'h0000_0000, 1'b1, 1'b1, "d/s3");
        tick(1'b0, 1'b1, "d/hold");
        strobe(32'h1234_56A5, 1'b0, 1'b1, "d/done");
        do_arm("d/rearm");

        // Level gating
        wr(2, 32'h0002_0000, 1'b0, "l/wcfg");
        lvl = 2'd1;
        do_arm("l/arm");
        strobe(32'h1234_56A5, 1'b0, 1'b0, "l/low1");
        strobe(32'h1234_56A5, 1'b0, 1'b0, "l/low2");
        lvl = 2'd2;
        strobe(32'h1234_56A5, 1'b1, 1'b0, "l/ok");
        lvl = 2'd0;

        // Arm coincident with delay expiry wins; then stage is re-armed
        wr(2, 32'h0800_0002, 1'b0, "a/wcfg");
        do_arm("a/arm");
        strobe(32'h1234_56A5, 1'b0, 1'b0, "a/hit");
        strobe(32'h0000_0000, 1'b0, 1'b0, "a/s1");
        arm = 1'b1;
        strobe(32'h0000_0000, 1'b0, 1'b0, "a/s2arm");
        strobe(32'h1234_56A5, 1'b0, 1'b0, "a/hit2");
        strobe(32'h0000_0000, 1'b0, 1'b0, "a/t1");
        strobe(32'h0000_0000, 1'b1, 1'b1, "a/t2");

        // Asynchronous reset in the middle of a delay
        do_arm("r/arm");
        strobe(32'h1234_56A5, 1'b0, 1'b0, "r/hit");
        #2;
        rst_n = 1'b0;
        #1;
        check("r/async/match", {31'd0, match}, 32'd0);
        check("r/async/run",   {31'd0, run},   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        strobe(32'h1234_56A5, 1'b0, 1'b0, "r/post1");
        strobe(32'h0000_0000, 1'b0, 1'b0, "r/post2");
        strobe(32'h1234_56A5, 1'b0, 1'b0, "r/post3");
        do_arm("r/arm2");
        strobe(32'hFFFF_FFFF, 1'b1, 1'b0, "r/cleared");

        // Serial channel compare (or parallel fallback without the option)
        wr(0, 32'h0000_000F, 1'b0, "s/wmask");
        wr(1, 32'h0000_000B, 1'b0, "s/wval");
        wr(2, 32'h0430_0000, 1'b0, "s/wcfg");
        do_arm("s/arm");
`ifdef STAGE_SERIAL_EN
        strobe(32'h0000_0008, 1'b0, 1'b0, "s/b1");
        strobe(32'h0000_0000, 1'b0, 1'b0, "s/b0");
        strobe(32'h0000_0008, 1'b0, 1'b0, "s/b1b");
        strobe(32'h0000_0008, 1'b1, 1'b0, "s/b1c");
`else
        strobe(32'h0000_0008, 1'b0, 1'b0, "s/par_miss");
        strobe(32'h0000_000B, 1'b1, 1'b0, "s/par_hit");
`endif
        tick(1'b0, 1'b0, "s/after");

        repeat (3) @(negedge clk);
        check("scoreboard/drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
